// File: rtl/sopc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sopc_run_ctrl
// Purpose  : Run controller for the SOPC. After reset it holds every reset
//            domain for RST_CYCLES, releases the domains one by one in index
//            order STAGGER cycles apart, then counts RUN cycles until the CPU
//            halts (PC unchanged for HALT_CYCLES compares) or the cycle budget
//            RUN_CYCLES runs out. A restart request replays the whole sequence.
// Ports    : clk          - single clock, posedge
//            rst          - synchronous active-low reset
//            restart_i    - synchronous request to replay the sequence
//            pc_i         - CPU fetch PC, observed only while running
//            dom_rst_o    - active-high reset per domain (bit 0 released first)
//            run_o        - high while the CPU is running
//            done_o       - sticky, run has ended
//            halted_o     - sticky, run ended because the PC stopped moving
//            timeout_o    - sticky, run ended because the budget ran out
//            cycle_cnt_o  - run cycles completed, frozen once done
// Revision : 1.0 - initial release
// ============================================================================
module sopc_run_ctrl #(
    parameter int NUM_DOM     = 2,
    parameter int RST_CYCLES  = 10,
    parameter int STAGGER     = 2,
    parameter int RUN_CYCLES  = 50,
    parameter int HALT_CYCLES = 8,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart_i,
    input  logic [31:0]        pc_i,
    output logic [NUM_DOM-1:0] dom_rst_o,
    output logic               run_o,
    output logic               done_o,
    output logic               halted_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   cycle_cnt_o
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] c_RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_STG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] c_RUN_MAX  = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] c_HALT_MAX = CNT_W'(HALT_CYCLES);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_DOM - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STAGGER = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [CNT_W-1:0]   stable_q,    stable_d;
    logic [31:0]        pc_prev_q,   pc_prev_d;
    logic [NUM_DOM-1:0] dom_rst_q,   dom_rst_d;
    logic               run_q,       run_d;
    logic               done_q,      done_d;
    logic               halted_q,    halted_d;
    logic               timeout_q,   timeout_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;

    // Values the run counters take if this cycle is a RUN cycle.
    logic [CNT_W-1:0] w_cyc_inc;
    logic [CNT_W-1:0] w_stable_inc;

    assign w_cyc_inc    = cycle_cnt_q + CNT_W'(1);
    assign w_stable_inc = (pc_i == pc_prev_q) ? (stable_q + CNT_W'(1)) : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stable_d    = stable_q;
        pc_prev_d   = pc_prev_q;
        dom_rst_d   = dom_rst_q;
        run_d       = run_q;
        done_d      = done_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        cycle_cnt_d = cycle_cnt_q;

        if (restart_i) begin
            // Restart reproduces the reset state one cycle later.
            state_d     = S_HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            stable_d    = '0;
            pc_prev_d   = '0;
            dom_rst_d   = '1;
            run_d       = 1'b0;
            done_d      = 1'b0;
            halted_d    = 1'b0;
            timeout_d   = 1'b0;
            cycle_cnt_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == c_RST_LAST) begin
                        dom_rst_d[0] = 1'b0;
                        cnt_d        = '0;
                        idx_d        = IDX_W'(1);
                        if (NUM_DOM == 1) begin
                            // Single domain: the only release starts the run.
                            state_d     = S_RUN;
                            run_d       = 1'b1;
                            cycle_cnt_d = '0;
                            stable_d    = '0;
                            pc_prev_d   = pc_i;
                        end else begin
                            state_d = S_STAGGER;
                        end
                    end
                end
                S_STAGGER: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == c_STG_LAST) begin
                        dom_rst_d[idx_q] = 1'b0;
                        cnt_d            = '0;
                        if (idx_q == c_LAST_IDX) begin
                            state_d     = S_RUN;
                            run_d       = 1'b1;
                            cycle_cnt_d = '0;
                            stable_d    = '0;
                            pc_prev_d   = pc_i;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    cycle_cnt_d = w_cyc_inc;
                    stable_d    = w_stable_inc;
                    pc_prev_d   = pc_i;
                    // Halt is tested first so a coincident timeout is masked.
                    if (w_stable_inc == c_HALT_MAX) begin
                        state_d  = S_DONE;
                        run_d    = 1'b0;
                        done_d   = 1'b1;
                        halted_d = 1'b1;
                    end else if (w_cyc_inc == c_RUN_MAX) begin
                        state_d   = S_DONE;
                        run_d     = 1'b0;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                S_DONE: begin
                    // Everything holds until rst or restart_i.
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            stable_q    <= '0;
            pc_prev_q   <= '0;
            dom_rst_q   <= '1;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stable_q    <= stable_d;
            pc_prev_q   <= pc_prev_d;
            dom_rst_q   <= dom_rst_d;
            run_q       <= run_d;
            done_q      <= done_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign dom_rst_o   = dom_rst_q;
    assign run_o       = run_q;
    assign done_o      = done_q;
    assign halted_o    = halted_q;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sopc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sopc_run_ctrl
// Purpose  : Self-checking bench for sopc_run_ctrl. Three instances with
//            different parameter sets share clk/rst/restart and each gets its
//            own PC stream. A timeline model predicts every output per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sopc_run_ctrl;

    // Instance parameter sets: default, 4-domain short run, single domain.
    localparam int M_ND  [3] = '{2, 4, 1};
    localparam int M_RST [3] = '{10, 5, 3};
    localparam int M_STG [3] = '{2, 3, 2};
    localparam int M_RUN [3] = '{50, 12, 20};
    localparam int M_HALT[3] = '{8, 4, 3};

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic [31:0] pc [3];

    logic [1:0]  d0_dom;
    logic [3:0]  d1_dom;
    logic [0:0]  d2_dom;
    logic [31:0] d0_cnt, d1_cnt;
    logic [15:0] d2_cnt;
    logic        o_run[3], o_done[3], o_halt[3], o_tmo[3];
    logic [3:0]  o_dom[3];
    logic [31:0] o_cnt[3];

    always #5 clk = ~clk;

    sopc_run_ctrl u_d0 (
        .clk(clk), .rst(rst), .restart_i(restart), .pc_i(pc[0]),
        .dom_rst_o(d0_dom), .run_o(o_run[0]), .done_o(o_done[0]),
        .halted_o(o_halt[0]), .timeout_o(o_tmo[0]), .cycle_cnt_o(d0_cnt)
    );

    sopc_run_ctrl #(
        .NUM_DOM(4), .RST_CYCLES(5), .STAGGER(3), .RUN_CYCLES(12),
        .HALT_CYCLES(4), .CNT_W(32)
    ) u_d1 (
        .clk(clk), .rst(rst), .restart_i(restart), .pc_i(pc[1]),
        .dom_rst_o(d1_dom), .run_o(o_run[1]), .done_o(o_done[1]),
        .halted_o(o_halt[1]), .timeout_o(o_tmo[1]), .cycle_cnt_o(d1_cnt)
    );

    sopc_run_ctrl #(
        .NUM_DOM(1), .RST_CYCLES(3), .STAGGER(2), .RUN_CYCLES(20),
        .HALT_CYCLES(3), .CNT_W(16)
    ) u_d2 (
        .clk(clk), .rst(rst), .restart_i(restart), .pc_i(pc[2]),
        .dom_rst_o(d2_dom), .run_o(o_run[2]), .done_o(o_done[2]),
        .halted_o(o_halt[2]), .timeout_o(o_tmo[2]), .cycle_cnt_o(d2_cnt)
    );

    assign o_dom[0] = {2'b00, d0_dom};
    assign o_dom[1] = d1_dom;
    assign o_dom[2] = {3'b000, d2_dom};
    assign o_cnt[0] = d0_cnt;
    assign o_cnt[1] = d1_cnt;
    assign o_cnt[2] = {16'h0000, d2_cnt};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Timeline model: m_t counts edges since the last rst/restart edge;
    // m_end is 0 while unfinished, 1 for halt, 2 for timeout.
    int          m_t   [3];
    int          m_end [3];
    int          m_last[3];   // RUN cycle at which the PC last changed
    logic [31:0] m_prev[3];

    function automatic int t_run(input int i);
        return M_RST[i] + (M_ND[i] - 1) * M_STG[i];
    endfunction

    task automatic model_edge(input int i, input bit r, input bit rs, input logic [31:0] p);
        int n;
        if (!r || rs) begin
            m_t[i]   = 0;
            m_end[i] = 0;
        end else if (m_end[i] == 0) begin
            m_t[i]++;
            n = m_t[i] - t_run(i);
            if (n == 0) begin
                m_prev[i] = p;
                m_last[i] = 0;
            end else if (n > 0) begin
                if (p != m_prev[i]) m_last[i] = n;
                m_prev[i] = p;
                if (n - m_last[i] >= M_HALT[i]) m_end[i] = 1;
                else if (n >= M_RUN[i])         m_end[i] = 2;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0]  e_dom;
        logic [31:0] e_cnt;
        for (int i = 0; i < 3; i++) begin
            e_dom = '0;
            for (int k = 0; k < M_ND[i]; k++)
                e_dom[k] = (m_t[i] < M_RST[i] + k * M_STG[i]);
            e_cnt = (m_t[i] >= t_run(i)) ? 32'(m_t[i] - t_run(i)) : 32'd0;
            chk($sformatf("d%0d.dom_rst", i), 32'(o_dom[i]), 32'(e_dom));
            chk($sformatf("d%0d.run", i),     32'(o_run[i]),
                32'(m_t[i] >= t_run(i) && m_end[i] == 0));
            chk($sformatf("d%0d.done", i),    32'(o_done[i]), 32'(m_end[i] != 0));
            chk($sformatf("d%0d.halted", i),  32'(o_halt[i]), 32'(m_end[i] == 1));
            chk($sformatf("d%0d.timeout", i), 32'(o_tmo[i]),  32'(m_end[i] == 2));
            chk($sformatf("d%0d.cycle_cnt", i), o_cnt[i], e_cnt);
        end
    endtask

    // PC stimulus: directed mode increments by 4 and freezes at 0x20 from a
    // chosen RUN cycle; random mode mostly holds, otherwise jumps.
    bit rnd_mode = 1'b0;
    int keep_pct = 80;
    int freeze_from[3] = '{-1, -1, -1};

    task automatic step(input bit r, input bit rs);
        int n_up;
        rst     = r;
        restart = rs;
        for (int i = 0; i < 3; i++) begin
            if (rnd_mode) begin
                if ($urandom_range(0, 99) >= keep_pct)
                    pc[i] = 32'($urandom_range(0, 3)) << 2;
            end else begin
                n_up = m_t[i] + 1 - t_run(i);
                if (freeze_from[i] >= 0 && n_up >= freeze_from[i]) pc[i] = 32'h20;
                else                                               pc[i] = pc[i] + 32'd4;
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, r, rs, pc[i]);
        #1;
        check_all();
    endtask

    initial begin
        int guard;
        rst     = 1'b0;
        restart = 1'b0;
        pc[0]   = 32'h0000_0100;
        pc[1]   = 32'h0000_1100;
        pc[2]   = 32'h0000_2100;

        // Reset held for 10 cycles, then release and let every run time out.
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 70; c++) step(1'b1, 1'b0);

        // Restart with PC freezes: d0 halts early, d1 halt meets timeout.
        freeze_from = '{5, 8, -1};
        step(1'b1, 1'b1);
        for (int c = 0; c < 70; c++) step(1'b1, 1'b0);

        // Restart again and interrupt d0 at RUN cycle 20.
        freeze_from = '{-1, -1, -1};
        step(1'b1, 1'b1);
        guard = 0;
        while (m_t[0] < t_run(0) + 20 && guard < 200) begin
            step(1'b1, 1'b0);
            guard++;
        end
        chk("reach_run_cycle_20", 32'(guard < 200), 32'd1);
        step(1'b1, 1'b1);
        for (int c = 0; c < 70; c++) step(1'b1, 1'b0);

        // rst asserted while d1 is in the middle of its staggered release.
        step(1'b1, 1'b1);
        guard = 0;
        while (m_t[1] < 8 && guard < 200) begin
            step(1'b1, 1'b0);
            guard++;
        end
        chk("reach_mid_stagger", 32'(guard < 200), 32'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int c = 0; c < 40; c++) step(1'b1, 1'b0);

        // Random traffic with occasional rst/restart.
        rnd_mode = 1'b1;
        for (int seg = 0; seg < 6; seg++) begin
            keep_pct = (seg % 2 == 0) ? 85 : 30;
            for (int c = 0; c < 500; c++)
                step($urandom_range(0, 199) != 0, $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
